// File: rtl/song_rom_if.sv
// Note ROM fetch bus: the sequencer requests {track, note_idx} and the ROM
// answers with {divider, length} qualified by rom_ack.
interface song_rom_if #(
    parameter int DIV_W  = 18,
    parameter int LEN_W  = 4,
    parameter int ADDR_W = 8,
    parameter int TRK_W  = 2
);
    logic                    rom_req;
    logic [TRK_W+ADDR_W-1:0] rom_addr;
    logic                    rom_ack;
    logic [DIV_W+LEN_W-1:0]  rom_data;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_data
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_data
    );
endinterface

// File: rtl/song_sequencer.sv
// Autoplay scheduler: fetches notes of the selected track from the note ROM,
// times them in beats and drives the tone divider, track number and playing flag.
module song_sequencer #(
    parameter int DIV_W      = 18,
    parameter int LEN_W      = 4,
    parameter int ADDR_W     = 8,
    parameter int TRK_W      = 2,
    parameter int BEAT_TICKS = 25000000,
    parameter int GAP_TICKS  = 2500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               play,
    input  logic               stop,
    input  logic               next_track,
    song_rom_if.master         rom,
    output logic [DIV_W-1:0]   tune,
    output logic [TRK_W+1:0]   track,
    output logic               playing
);
    // Sized so that 15 beats never overflow the down-counter.
    localparam int CNT_W = LEN_W + $clog2(BEAT_TICKS);
    localparam logic [CNT_W-1:0]  BEAT_C   = CNT_W'(BEAT_TICKS);
    localparam logic [CNT_W-1:0]  GAP_C    = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SOUND,
        GAP
    } state_t;

    state_t                  state, state_nx;
    logic                    req, req_nx;
    logic [TRK_W+ADDR_W-1:0] addr, addr_nx;
    logic [DIV_W-1:0]        tune_r, tune_nx;
    logic [TRK_W-1:0]        trk, trk_nx;
    logic                    play_r, play_nx;
    logic [ADDR_W-1:0]       idx, idx_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;

    logic [DIV_W-1:0]        note_div;
    logic [LEN_W-1:0]        note_len;
    logic [CNT_W-1:0]        sound_ticks;

    assign note_div    = rom.rom_data[DIV_W+LEN_W-1:LEN_W];
    assign note_len    = rom.rom_data[LEN_W-1:0];
    assign sound_ticks = CNT_W'(note_len) * BEAT_C - GAP_C - CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            req    <= 1'b0;
            addr   <= '0;
            tune_r <= '0;
            trk    <= '0;
            play_r <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            req    <= req_nx;
            addr   <= addr_nx;
            tune_r <= tune_nx;
            trk    <= trk_nx;
            play_r <= play_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req_nx   = req;
        addr_nx  = addr;
        tune_nx  = tune_r;
        trk_nx   = trk;
        play_nx  = play_r;
        idx_nx   = idx;
        cnt_nx   = cnt;

        case (state)
            IDLE: begin
                tune_nx = '0;
                play_nx = 1'b0;
                if (play && !next_track && !stop) begin
                    state_nx = FETCH;
                    idx_nx   = '0;
                    req_nx   = 1'b1;
                    addr_nx  = {trk, {ADDR_W{1'b0}}};
                    play_nx  = 1'b1;
                end
            end

            FETCH: begin
                // A low request here means a withdrawn fetch: reissue it at the new address.
                if (!req) begin
                    req_nx  = 1'b1;
                    addr_nx = {trk, idx};
                end else if (rom.rom_ack) begin
                    req_nx = 1'b0;
                    if (note_len == '0) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        tune_nx  = '0;
                        play_nx  = 1'b0;
                    end else begin
                        state_nx = SOUND;
                        tune_nx  = note_div;
                        cnt_nx   = sound_ticks;
                    end
                end
            end

            SOUND: begin
                if (cnt == '0) begin
                    state_nx = GAP;
                    tune_nx  = '0;
                    cnt_nx   = GAP_C - CNT_ONE;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end

            GAP: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_ONE;
                end else if (idx == LAST_IDX) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    play_nx  = 1'b0;
                end else begin
                    state_nx = FETCH;
                    idx_nx   = idx + ADDR_W'(1);
                    req_nx   = 1'b1;
                    addr_nx  = {trk, idx + ADDR_W'(1)};
                end
            end

            default: state_nx = IDLE;
        endcase

        if (next_track) begin
            trk_nx = trk + TRK_W'(1);
            idx_nx = '0;
            if (state != IDLE) begin
                state_nx = FETCH;
                tune_nx  = '0;
                req_nx   = 1'b0;
            end
        end

        // stop wins over everything, but a simultaneous track advance is kept.
        if (stop) begin
            state_nx = IDLE;
            tune_nx  = '0;
            play_nx  = 1'b0;
            req_nx   = 1'b0;
            idx_nx   = '0;
        end
    end

    assign rom.rom_req  = req;
    assign rom.rom_addr = addr;
    assign tune         = tune_r;
    assign track        = {2'b00, trk};
    assign playing      = play_r;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a small registered note ROM model
// (programmable stall) and short beat timing.
module tb_song_sequencer;
    localparam int DIV_W  = 18;
    localparam int LEN_W  = 4;
    localparam int ADDR_W = 8;
    localparam int TRK_W  = 2;

    logic clk = 1'b0;
    logic rst, play, stop, next_track;
    logic [DIV_W-1:0] tune;
    logic [TRK_W+1:0] track;
    logic             playing;

    song_rom_if #(.DIV_W(DIV_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .TRK_W(TRK_W)) rom_bus ();

    song_sequencer #(
        .DIV_W(DIV_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .TRK_W(TRK_W),
        .BEAT_TICKS(10), .GAP_TICKS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .play       (play),
        .stop       (stop),
        .next_track (next_track),
        .rom        (rom_bus.master),
        .tune       (tune),
        .track      (track),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    // Note ROM: registered data, ack one cycle after request plus stall_cfg extra cycles.
    logic [DIV_W+LEN_W-1:0] mem [0:1023];
    logic [DIV_W+LEN_W-1:0] data_q;
    logic                   ack_q = 1'b0;
    logic                   force_ack;
    int                     waited = 0;
    int                     stall_cfg;

    always @(posedge clk) begin
        data_q <= mem[rom_bus.rom_addr];
        if (rom_bus.rom_req && !ack_q) begin
            if (waited >= stall_cfg) ack_q <= 1'b1;
            else waited <= waited + 1;
        end else begin
            ack_q  <= 1'b0;
            waited <= 0;
        end
    end

    assign rom_bus.rom_ack  = ack_q | force_ack;
    assign rom_bus.rom_data = data_q;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIV_W+LEN_W-1:0] note(input int d, input int l);
        return {DIV_W'(d), LEN_W'(l)};
    endfunction

    initial begin
        int n;
        logic ok;
        logic [9:0] held;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0]   = note(95556, 2);
        mem[256] = note(0, 1);
        for (int i = 1; i <= 5; i++) mem[256 + i] = note(1000 + i, 3);
        mem[512] = note(50000, 1);
        for (int i = 0; i < 256; i++) mem[768 + i] = note(100 + i, 1);

        rst = 1'b1; play = 1'b0; stop = 1'b0; next_track = 1'b0;
        force_ack = 1'b0; stall_cfg = 0;

        // Reset
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_req", 32'(rom_bus.rom_req), 0);
        check("rst_addr", 32'(rom_bus.rom_addr), 0);
        check("rst_tune", 32'(tune), 0);
        check("rst_track", 32'(track), 0);
        check("rst_playing", 32'(playing), 0);
        force_ack = 1'b1; tick(); force_ack = 1'b0; tick();
        check("stray_ack_req", 32'(rom_bus.rom_req), 0);
        check("stray_ack_tune", 32'(tune), 0);
        check("stray_ack_playing", 32'(playing), 0);

        // Single note on track 0
        play = 1'b1; tick(); play = 1'b0;
        check("play_req", 32'(rom_bus.rom_req), 1);
        check("play_addr", 32'(rom_bus.rom_addr), 0);
        check("play_playing", 32'(playing), 1);
        tick();
        check("fetch_tune_pre", 32'(tune), 0);
        tick();
        check("note_tune", 32'(tune), 95556);
        check("note_req_drop", 32'(rom_bus.rom_req), 0);
        n = 0;
        while (tune == 18'd95556 && n < 100) begin n++; tick(); end
        check("sound_cycles", 32'(n), 18);
        n = 0;
        while (tune == '0 && !rom_bus.rom_req && n < 100) begin n++; tick(); end
        check("gap_cycles", 32'(n), 2);
        check("next_fetch_addr", 32'(rom_bus.rom_addr), 1);
        tick();
        check("end_fetch_playing", 32'(playing), 1);
        tick();
        check("end_playing", 32'(playing), 0);
        check("end_tune", 32'(tune), 0);
        check("end_req", 32'(rom_bus.rom_req), 0);

        // Handshake stall
        stall_cfg = 6;
        play = 1'b1; tick(); play = 1'b0;
        held = rom_bus.rom_addr;
        ok = 1'b1;
        n = 0;
        while (rom_bus.rom_req && !rom_bus.rom_ack && n < 50) begin
            if (rom_bus.rom_addr !== held || tune !== '0) ok = 1'b0;
            n++; tick();
        end
        check("stall_cycles", 32'(n), 7);
        check("stall_stable", 32'(ok), 1);
        check("stall_ack_req", 32'(rom_bus.rom_req), 1);
        check("stall_ack_tune", 32'(tune), 0);
        stall_cfg = 0;
        tick();
        check("stall_tune", 32'(tune), 95556);
        n = 0;
        while (playing && n < 100) begin n++; tick(); end
        check("stall_done", 32'(playing), 0);

        // Rest note on track 1
        next_track = 1'b1; tick(); next_track = 1'b0;
        check("idle_next_track", 32'(track), 1);
        check("idle_next_playing", 32'(playing), 0);
        check("idle_next_req", 32'(rom_bus.rom_req), 0);
        play = 1'b1; tick(); play = 1'b0;
        check("rest_addr", 32'(rom_bus.rom_addr), 256);
        tick(); tick();
        ok = 1'b1;
        n = 0;
        while (!rom_bus.rom_req && n < 50) begin
            if (tune !== '0) ok = 1'b0;
            n++; tick();
        end
        check("rest_cycles", 32'(n), 10);
        check("rest_silent", 32'(ok), 1);
        check("rest_next_addr", 32'(rom_bus.rom_addr), 257);

        // Mid-note track switch during note 5 of track 1
        n = 0;
        while (!(rom_bus.rom_req && rom_bus.rom_addr == 10'd261) && n < 500) begin n++; tick(); end
        check("reach_note5", 32'(rom_bus.rom_addr), 261);
        tick(); tick();
        check("note5_tune", 32'(tune), 1005);
        tick(); tick();
        next_track = 1'b1; tick(); next_track = 1'b0;
        check("switch_tune", 32'(tune), 0);
        check("switch_req_drop", 32'(rom_bus.rom_req), 0);
        check("switch_track", 32'(track), 2);
        check("switch_playing", 32'(playing), 1);
        tick();
        check("switch_req", 32'(rom_bus.rom_req), 1);
        check("switch_addr", 32'(rom_bus.rom_addr), 512);
        check("switch_playing2", 32'(playing), 1);
        tick(); tick();
        check("trk2_tune", 32'(tune), 50000);
        n = 0;
        while (playing && n < 100) begin n++; tick(); end
        check("trk2_done", 32'(playing), 0);

        // Full track 3: note index wraps into end of track
        next_track = 1'b1; tick(); next_track = 1'b0;
        check("to_track3", 32'(track), 3);
        play = 1'b1; tick(); play = 1'b0;
        n = 0;
        for (int c = 0; c < 5000 && playing; c++) begin
            if (rom_bus.rom_req && rom_bus.rom_ack) n++;
            tick();
        end
        check("wrap_fetches", 32'(n), 256);
        check("wrap_playing", 32'(playing), 0);
        check("wrap_last_addr", 32'(rom_bus.rom_addr), 1023);
        next_track = 1'b1; tick(); next_track = 1'b0;
        check("track_wrap", 32'(track), 0);

        // stop + next_track together while sounding
        play = 1'b1; tick(); play = 1'b0;
        check("replay_addr", 32'(rom_bus.rom_addr), 0);
        tick(); tick(); tick();
        check("replay_tune", 32'(tune), 95556);
        stop = 1'b1; next_track = 1'b1; tick(); stop = 1'b0; next_track = 1'b0;
        check("stopnext_track", 32'(track), 1);
        check("stopnext_playing", 32'(playing), 0);
        check("stopnext_tune", 32'(tune), 0);
        check("stopnext_req", 32'(rom_bus.rom_req), 0);
        tick();
        check("stopnext_idle", 32'(rom_bus.rom_req), 0);

        // play + next_track in IDLE: only the track moves
        play = 1'b1; next_track = 1'b1; tick(); play = 1'b0; next_track = 1'b0;
        check("playnext_track", 32'(track), 2);
        check("playnext_playing", 32'(playing), 0);
        tick();
        check("playnext_req", 32'(rom_bus.rom_req), 0);

        // Reset during a stalled fetch, then a late ack
        stall_cfg = 20;
        play = 1'b1; tick(); play = 1'b0;
        tick();
        check("rstfetch_req_pre", 32'(rom_bus.rom_req), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstfetch_req", 32'(rom_bus.rom_req), 0);
        check("rstfetch_playing", 32'(playing), 0);
        check("rstfetch_track", 32'(track), 0);
        check("rstfetch_addr", 32'(rom_bus.rom_addr), 0);
        stall_cfg = 0;
        force_ack = 1'b1; tick(); force_ack = 1'b0; tick();
        check("late_ack_tune", 32'(tune), 0);
        check("late_ack_req", 32'(rom_bus.rom_req), 0);
        check("late_ack_playing", 32'(playing), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
